// File: rtl/traffic_interval_timer.sv
// Interval counter, select tracker and car-sensor debouncer feeding the
// traffic-light controller FSM with its four branch flags.
module traffic_interval_timer #(
    parameter int CNT_W   = 8,
    parameter int T_YEL   = 4,
    parameter int T_RED   = 2,
    parameter int T_NGRN  = 10,
    parameter int T_EGRN  = 6,
    parameter int DEB_CYC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             car_e,
    input  logic [1:0]       s_IC,
    input  logic             en_IC,
    output logic             not_r,
    output logic             c_and_l,
    output logic             en_s,
    output logic             l_or_notc,
    output logic             car_q,
    output logic [CNT_W-1:0] cnt_q
);

    localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

    logic [1:0]       sel_q, sel_d;
    logic             sel_vld_q, sel_vld_d;
    logic [CNT_W-1:0] cnt_d;
    logic             sync1_q, car_s_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             car_d;
    logic             match, done;

    function automatic logic [CNT_W-1:0] reload_val(input logic [1:0] s);
        logic [CNT_W-1:0] v;
        case (s)
            2'b00:   v = CNT_W'(T_YEL - 1);
            2'b01:   v = CNT_W'(T_RED - 1);
            2'b10:   v = CNT_W'(T_NGRN - 1);
            default: v = CNT_W'(T_EGRN - 1);
        endcase
        return v;
    endfunction

    assign match = en_IC & sel_vld_q & (s_IC == sel_q);
    assign done  = (cnt_q == '0);

    // Any enabled cycle that does not continue the tracked select is a load.
    always_comb begin
        sel_d     = sel_q;
        sel_vld_d = sel_vld_q;
        cnt_d     = cnt_q;
        if (!en_IC) begin
            sel_vld_d = 1'b0;
        end else if (!match) begin
            cnt_d     = reload_val(s_IC);
            sel_d     = s_IC;
            sel_vld_d = 1'b1;
        end else if (!done) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        car_d     = car_q;
        deb_cnt_d = '0;
        if (car_s_q != car_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                car_d = car_s_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= 2'b00;
            sel_vld_q <= 1'b0;
            cnt_q     <= '0;
            sync1_q   <= 1'b0;
            car_s_q   <= 1'b0;
            deb_cnt_q <= '0;
            car_q     <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            sel_vld_q <= sel_vld_d;
            cnt_q     <= cnt_d;
            sync1_q   <= car_e;
            car_s_q   <= sync1_q;
            deb_cnt_q <= deb_cnt_d;
            car_q     <= car_d;
        end
    end

    // Every flag is gated by match so a stale count never leaks across a load.
    assign en_s      = match & (sel_q == 2'b00) & done;
    assign not_r     = match & (sel_q == 2'b01) & done;
    assign c_and_l   = match & (sel_q == 2'b10) & done & car_q;
    assign l_or_notc = match & (sel_q == 2'b11) & (done | ~car_q);

endmodule
